// File: rtl/switch_input_device_pkg.sv
// Shared constants for the switch input peripheral: default register
// addresses, CTRL bit positions and the read-select encoding.
package switch_input_device_pkg;

  localparam logic [31:0] ADDR_DATA_DEFAULT = 32'hF000_0014;
  localparam logic [31:0] ADDR_CTRL_DEFAULT = 32'hF000_0114;

  localparam int unsigned CTRL_READY_BIT   = 0;
  localparam int unsigned CTRL_OVERRUN_BIT = 1;
  localparam int unsigned CTRL_IE_BIT      = 8;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_DATA,
    SEL_CTRL
  } reg_sel_e;

endpackage

// File: rtl/switch_input_device_sync_debounce.sv
// Two-flop synchronizer plus saturating-count debouncer; pulses commit when a
// candidate has been stable long enough and differs from the current value.
module switch_input_device_sync_debounce #(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  input  logic [WIDTH-1:0] current,
  output logic [WIDTH-1:0] stable,
  output logic             commit
);

  localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  // Drops by itself one cycle later because the owner then holds cand.
  assign stable = cand;
  assign commit = (cnt == CNT_MAX) && (cand != current);

endmodule

// File: rtl/switch_input_device.sv
// Memory-mapped debounced switch input: DATA/CTRL registers on the shared
// bus, ready/overrun status and a level interrupt.
module switch_input_device
  import switch_input_device_pkg::*;
#(
  parameter int unsigned          BIT_WIDTH       = 32,
  parameter int unsigned          SW_WIDTH        = 10,
  parameter int unsigned          DEBOUNCE_CYCLES = 100000,
  parameter logic [BIT_WIDTH-1:0] ADDR_DATA       = BIT_WIDTH'(ADDR_DATA_DEFAULT),
  parameter logic [BIT_WIDTH-1:0] ADDR_CTRL       = BIT_WIDTH'(ADDR_CTRL_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] aBus,
  input  logic                 rdEn,
  input  logic                 wrtEn,
  input  logic [BIT_WIDTH-1:0] dBusIn,
  output logic [BIT_WIDTH-1:0] dBusOut,
  input  logic [SW_WIDTH-1:0]  swIn,
  output logic                 intr
);

  logic [SW_WIDTH-1:0] data;
  logic [SW_WIDTH-1:0] stable;
  logic                commit;
  logic                ready;
  logic                overrun;
  logic                ie;
  logic                data_rd;
  logic                ctrl_wr;
  logic                ready_clr;
  logic                overrun_clr;
  logic                unused_dbus;
  reg_sel_e            sel;

  switch_input_device_sync_debounce #(
    .WIDTH          (SW_WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk    (clk),
    .reset  (reset),
    .sw_in  (swIn),
    .current(data),
    .stable (stable),
    .commit (commit)
  );

  assign data_rd     = rdEn && (aBus == ADDR_DATA);
  assign ctrl_wr     = wrtEn && (aBus == ADDR_CTRL);
  assign ready_clr   = data_rd || (ctrl_wr && !dBusIn[CTRL_READY_BIT]);
  assign overrun_clr = ctrl_wr && !dBusIn[CTRL_OVERRUN_BIT];
  assign unused_dbus = ^dBusIn;

  // Commit has priority over both clears; overrun only latches when the
  // previous value was still unread at the moment of the new commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data    <= '0;
      ready   <= 1'b0;
      overrun <= 1'b0;
      ie      <= 1'b0;
    end else begin
      if (commit) begin
        data  <= stable;
        ready <= 1'b1;
      end else if (ready_clr) begin
        ready <= 1'b0;
      end
      if (commit && ready && !ready_clr) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
      if (ctrl_wr) begin
        ie <= dBusIn[CTRL_IE_BIT];
      end
    end
  end

  always_comb begin
    sel = SEL_NONE;
    if (rdEn && (aBus == ADDR_DATA)) begin
      sel = SEL_DATA;
    end else if (rdEn && (aBus == ADDR_CTRL)) begin
      sel = SEL_CTRL;
    end
  end

  always_comb begin
    dBusOut = '0;
    case (sel)
      SEL_DATA: dBusOut[SW_WIDTH-1:0] = data;
      SEL_CTRL: begin
        dBusOut[CTRL_READY_BIT]   = ready;
        dBusOut[CTRL_OVERRUN_BIT] = overrun;
        dBusOut[CTRL_IE_BIT]      = ie;
      end
      default: ;
    endcase
  end

  assign intr = ready & ie;

endmodule

// File: tb/tb_switch_input_device.sv
// Directed bench for switch_input_device with a 4-cycle debounce window.
module tb_switch_input_device;

  localparam logic [31:0] A_DATA = 32'hF000_0014;
  localparam logic [31:0] A_CTRL = 32'hF000_0114;
  localparam logic [31:0] A_NONE = 32'hF000_0018;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] aBus = '0;
  logic        rdEn = 1'b0;
  logic        wrtEn = 1'b0;
  logic [31:0] dBusIn = '0;
  logic [31:0] dBusOut;
  logic [9:0]  swIn = '0;
  logic        intr;

  int total = 0;
  int bad = 0;

  switch_input_device #(
    .BIT_WIDTH      (32),
    .SW_WIDTH       (10),
    .DEBOUNCE_CYCLES(4),
    .ADDR_DATA      (A_DATA),
    .ADDR_CTRL      (A_CTRL)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .aBus   (aBus),
    .rdEn   (rdEn),
    .wrtEn  (wrtEn),
    .dBusIn (dBusIn),
    .dBusOut(dBusOut),
    .swIn   (swIn),
    .intr   (intr)
  );

  always #5 clk = ~clk;

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Combinational look at a register without letting rdEn reach a clock edge.
  task automatic peek(input logic [31:0] addr, output logic [31:0] d);
    aBus = addr;
    rdEn = 1'b1;
    #1;
    d = dBusOut;
    rdEn = 1'b0;
    aBus = '0;
    #1;
  endtask

  task automatic write_reg(input logic [31:0] addr, input logic [31:0] val);
    aBus = addr;
    dBusIn = val;
    wrtEn = 1'b1;
    @(posedge clk);
    #1;
    wrtEn = 1'b0;
    aBus = '0;
    dBusIn = '0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b0;
    edges(3);
    total++;
    if (intr !== 1'b0) begin bad++; $display("FAIL reset_intr: got %b expected 0", intr); end
    peek(A_CTRL, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h expected 00000000", d); end
    reset = 1'b1;
    edges(10);
    peek(A_CTRL, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL idle_ctrl: got %h expected 00000000", d); end
  endtask

  task automatic test_first_commit;
    logic [31:0] d;
    swIn = 10'h155;
    edges(7);
    peek(A_CTRL, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL early_ctrl: got %h expected 00000000", d); end
    peek(A_DATA, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL early_data: got %h expected 00000000", d); end
    edges(1);
    peek(A_DATA, d);
    total++;
    if (d !== 32'h155) begin bad++; $display("FAIL commit_data: got %h expected 00000155", d); end
    peek(A_CTRL, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL commit_ctrl: got %h expected 00000001", d); end
    total++;
    if (intr !== 1'b0) begin bad++; $display("FAIL commit_intr_masked: got %b expected 0", intr); end
    peek(A_NONE, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL unmatched_addr: got %h expected 00000000", d); end
  endtask

  task automatic test_interrupt;
    logic [31:0] d;
    write_reg(A_CTRL, 32'h100);
    peek(A_CTRL, d);
    total++;
    if (d !== 32'h100) begin bad++; $display("FAIL ie_ctrl: got %h expected 00000100", d); end
    swIn = 10'h0AA;
    edges(8);
    total++;
    if (intr !== 1'b1) begin bad++; $display("FAIL intr_set: got %b expected 1", intr); end
    aBus = A_DATA;
    rdEn = 1'b1;
    #1;
    total++;
    if (dBusOut !== 32'h0AA) begin bad++; $display("FAIL read_data: got %h expected 000000aa", dBusOut); end
    @(posedge clk);
    #1;
    rdEn = 1'b0;
    aBus = '0;
    total++;
    if (intr !== 1'b0) begin bad++; $display("FAIL intr_clear: got %b expected 0", intr); end
    peek(A_CTRL, d);
    total++;
    if (d !== 32'h100) begin bad++; $display("FAIL read_clears_ready: got %h expected 00000100", d); end
  endtask

  task automatic test_glitch;
    logic [31:0] d;
    swIn = 10'h3FF;
    edges(3);
    swIn = 10'h0AA;
    edges(12);
    peek(A_DATA, d);
    total++;
    if (d !== 32'h0AA) begin bad++; $display("FAIL glitch_data: got %h expected 000000aa", d); end
    peek(A_CTRL, d);
    total++;
    if (d !== 32'h100) begin bad++; $display("FAIL glitch_ctrl: got %h expected 00000100", d); end
  endtask

  task automatic test_overrun;
    logic [31:0] d;
    write_reg(A_CTRL, 32'h0);
    swIn = 10'h001;
    edges(8);
    swIn = 10'h002;
    edges(8);
    peek(A_CTRL, d);
    total++;
    if (d !== 32'h3) begin bad++; $display("FAIL overrun_ctrl: got %h expected 00000003", d); end
    peek(A_DATA, d);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL overrun_data: got %h expected 00000002", d); end
    write_reg(A_DATA, 32'h0);
    peek(A_DATA, d);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL data_write_ignored: got %h expected 00000002", d); end
    write_reg(A_CTRL, 32'h3);
    peek(A_CTRL, d);
    total++;
    if (d !== 32'h3) begin bad++; $display("FAIL ctrl_write_ones: got %h expected 00000003", d); end
    write_reg(A_CTRL, 32'h0);
    peek(A_CTRL, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL ctrl_clear: got %h expected 00000000", d); end
  endtask

  task automatic test_read_collision;
    logic [31:0] d;
    swIn = 10'h003;
    edges(8);
    peek(A_CTRL, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL pre_collision_ctrl: got %h expected 00000001", d); end
    swIn = 10'h004;
    edges(7);
    aBus = A_DATA;
    rdEn = 1'b1;
    #1;
    total++;
    if (dBusOut !== 32'h3) begin bad++; $display("FAIL collision_old_data: got %h expected 00000003", dBusOut); end
    @(posedge clk);
    #1;
    rdEn = 1'b0;
    aBus = '0;
    peek(A_DATA, d);
    total++;
    if (d !== 32'h4) begin bad++; $display("FAIL collision_data: got %h expected 00000004", d); end
    peek(A_CTRL, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL collision_ctrl: got %h expected 00000001", d); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    write_reg(A_CTRL, 32'h101);
    total++;
    if (intr !== 1'b1) begin bad++; $display("FAIL pre_reset_intr: got %b expected 1", intr); end
    swIn = 10'h2AA;
    edges(3);
    reset = 1'b0;
    #1;
    total++;
    if (intr !== 1'b0) begin bad++; $display("FAIL async_reset_intr: got %b expected 0", intr); end
    peek(A_DATA, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL async_reset_data: got %h expected 00000000", d); end
    peek(A_CTRL, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL async_reset_ctrl: got %h expected 00000000", d); end
    edges(2);
    reset = 1'b1;
    edges(7);
    peek(A_CTRL, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL post_reset_early_ctrl: got %h expected 00000000", d); end
    edges(1);
    peek(A_DATA, d);
    total++;
    if (d !== 32'h2AA) begin bad++; $display("FAIL post_reset_data: got %h expected 000002aa", d); end
    peek(A_CTRL, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL post_reset_ctrl: got %h expected 00000001", d); end
    total++;
    if (intr !== 1'b0) begin bad++; $display("FAIL post_reset_intr: got %b expected 0", intr); end
  endtask

  initial begin
    test_reset();
    test_first_commit();
    test_interrupt();
    test_glitch();
    test_overrun();
    test_read_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
